vga_fb_reader: RTL and testbench

VGA_FB_READER -- requirements
Module: vga_fb_reader

---
 rtl/vga_fb_reader.sv | 177 +++++++++++++++++
 tb/tb_vga_fb_reader.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_reader.sv
// ---------------------------------------------------------------------------
// vga_fb_reader
//   Scans a 320x240 RGB444 frame buffer out to a 640x480 VGA timing grid.
//   Each stored pixel is shown as a 2x2 block. Sync and blank are delayed
//   by two clocks so they line up with the pixel data: one clock for the
//   address register and one clock for the frame buffer read latency.
//
// Ports
//   clk           pixel clock; also clocks the frame buffer read port
//   reset_n       asynchronous active-low reset
//   filter_select 1 = grayscale output, 0 = colour passthrough
//   rdaddress     frame buffer read address (row-major, 320 words per row)
//   rddata        frame buffer read data {R,G,B} 4 bits each, valid one
//                 clock after rdaddress
//   vga_hs/vga_vs active-low sync outputs
//   vga_blank_n   high while the visible area is being output
//   vga_r/g/b     8-bit pixel colour, forced to 0 while blanked
//   frame_start   one-clock pulse when the counters pass h=0, v=0; it is
//                 registered alongside rdaddress, not delayed to the output
// ---------------------------------------------------------------------------
module vga_fb_reader #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        filter_select,
  output logic [16:0] rdaddress,
  input  logic [11:0] rddata,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LAST_C = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HS_BEG_C = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END_C = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_LAST_C = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VS_BEG_C = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END_C = VW'(V_ACTIVE + V_FP + V_SYNC);

  // Row pitch of the frame buffer in words.
  localparam logic [16:0] ROW_PITCH = 17'd320;

  // Counter stage
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  // Address of the first word of the buffer row for the current line;
  // stepping it by ROW_PITCH every second line avoids a multiplier.
  logic [16:0]   row_base_q, row_base_d;
  logic          in_active;

  // Stage 1: address register plus timing signals for the same position
  logic [16:0]   rdaddress_q, rdaddress_d;
  logic          frame_start_q, frame_start_d;
  logic          hs1_q, hs1_d;
  logic          vs1_q, vs1_d;
  logic          blank1_q, blank1_d;

  // Stage 2: timing signals aligned with rddata
  logic          hs2_q, hs2_d;
  logic          vs2_q, vs2_d;
  logic          blank2_q, blank2_d;

  // Colour path
  logic [5:0]    luma_sum;
  logic [3:0]    luma;

  always_comb begin
    in_active  = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);

    h_cnt_d    = h_cnt_q + 1'b1;
    v_cnt_d    = v_cnt_q;
    row_base_d = row_base_q;
    if (h_cnt_q == H_LAST_C) begin
      h_cnt_d = '0;
      if (v_cnt_q == V_LAST_C) begin
        v_cnt_d    = '0;
        row_base_d = '0;
      end else begin
        v_cnt_d = v_cnt_q + 1'b1;
        // Leaving an odd line moves on to the next buffer row.
        if (v_cnt_q[0] && (v_cnt_q < V_ACT_C)) begin
          row_base_d = row_base_q + ROW_PITCH;
        end
      end
    end

    // Outside the visible area the address simply holds.
    rdaddress_d = rdaddress_q;
    if (in_active) begin
      rdaddress_d = row_base_q + 17'(h_cnt_q >> 1);
    end

    frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    hs1_d         = !((h_cnt_q >= HS_BEG_C) && (h_cnt_q < HS_END_C));
    vs1_d         = !((v_cnt_q >= VS_BEG_C) && (v_cnt_q < VS_END_C));
    blank1_d      = in_active;

    hs2_d         = hs1_q;
    vs2_d         = vs1_q;
    blank2_d      = blank1_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      row_base_q    <= '0;
      rdaddress_q   <= '0;
      frame_start_q <= 1'b0;
      hs1_q         <= 1'b1;
      vs1_q         <= 1'b1;
      blank1_q      <= 1'b0;
      hs2_q         <= 1'b1;
      vs2_q         <= 1'b1;
      blank2_q      <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      row_base_q    <= row_base_d;
      rdaddress_q   <= rdaddress_d;
      frame_start_q <= frame_start_d;
      hs1_q         <= hs1_d;
      vs1_q         <= vs1_d;
      blank1_q      <= blank1_d;
      hs2_q         <= hs2_d;
      vs2_q         <= vs2_d;
      blank2_q      <= blank2_d;
    end
  end

  // The RGB stage is combinational on rddata, which the frame buffer
  // already registers, so filter_select acts on the pixel currently shown.
  always_comb begin
    luma_sum = {2'b00, rddata[11:8]} + {1'b0, rddata[7:4], 1'b0} + {2'b00, rddata[3:0]};
    luma     = luma_sum[5:2];
    vga_r    = 8'h00;
    vga_g    = 8'h00;
    vga_b    = 8'h00;
    if (blank2_q) begin
      if (filter_select) begin
        vga_r = {luma, luma};
        vga_g = {luma, luma};
        vga_b = {luma, luma};
      end else begin
        vga_r = {rddata[11:8], rddata[11:8]};
        vga_g = {rddata[7:4], rddata[7:4]};
        vga_b = {rddata[3:0], rddata[3:0]};
      end
    end
  end

  assign rdaddress   = rdaddress_q;
  assign frame_start = frame_start_q;
  assign vga_hs      = hs2_q;
  assign vga_vs      = vs2_q;
  assign vga_blank_n = blank2_q;

endmodule

// File: tb/tb_vga_fb_reader.sv
// ---------------------------------------------------------------------------
// tb_vga_fb_reader
//   Bench for vga_fb_reader. Instance dut uses the default 640x480 timing;
//   instance mini uses a scaled-down timing so whole frames fit in a short
//   run. Each has a frame buffer model returning rddata = rdaddress[11:0]
//   one clock after the address. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_vga_fb_reader;

  localparam int HT  = 800;
  localparam int VT  = 525;
  localparam int HA  = 640;
  localparam int VA  = 480;
  localparam int HS0 = 656;
  localparam int HS1 = 752;
  localparam int VS0 = 490;
  localparam int VS1 = 492;

  localparam int MHT = 24;
  localparam int MVT = 12;
  localparam int MHA = 16;
  localparam int MVA = 8;

  // ---------------- clock ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- default-timing instance ----------------
  logic        reset_n;
  logic        filter_select;
  logic [16:0] rdaddress;
  logic [11:0] rddata;
  logic [11:0] ram_q;
  logic [11:0] force_data;
  logic        force_en;
  logic        hs, vs, blank_n, frame_start;
  logic [7:0]  r, g, b;

  vga_fb_reader dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .filter_select(filter_select),
    .rdaddress    (rdaddress),
    .rddata       (rddata),
    .vga_hs       (hs),
    .vga_vs       (vs),
    .vga_blank_n  (blank_n),
    .vga_r        (r),
    .vga_g        (g),
    .vga_b        (b),
    .frame_start  (frame_start)
  );

  always @(posedge clk) ram_q <= rdaddress[11:0];
  assign rddata = force_en ? force_data : ram_q;

  // ---------------- scaled-timing instance ----------------
  logic        m_reset_n;
  logic        m_filter;
  logic [16:0] m_rdaddress;
  logic [11:0] m_rddata;
  logic        m_hs, m_vs, m_blank_n, m_frame_start;
  logic [7:0]  m_r, m_g, m_b;

  vga_fb_reader #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) mini (
    .clk          (clk),
    .reset_n      (m_reset_n),
    .filter_select(m_filter),
    .rdaddress    (m_rdaddress),
    .rddata       (m_rddata),
    .vga_hs       (m_hs),
    .vga_vs       (m_vs),
    .vga_blank_n  (m_blank_n),
    .vga_r        (m_r),
    .vga_g        (m_g),
    .vga_b        (m_b),
    .frame_start  (m_frame_start)
  );

  always @(posedge clk) m_rddata <= m_rdaddress[11:0];

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;
  int k_a   = 0;
  int k_m   = 0;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // One clock: returns on the following falling edge.
  task automatic step();
    @(posedge clk);
    k_a++;
    k_m++;
    @(negedge clk);
  endtask

  function automatic int fb_addr(input int h, input int v);
    return (v / 2) * 320 + h / 2;
  endfunction

  typedef struct {
    logic        fsel;
    logic [11:0] data;
    logic [23:0] exp_rgb;
  } vec_t;

  vec_t vecs[11];

  int          p, q, h, v, exp_rd, exp_m, max_m;
  int          e_hs, e_vs, e_bl;
  logic [23:0] e_rgb;
  logic [11:0] d;
  logic        fsel;
  logic        prev_hs;
  int          hs_f0, hs_f1, hs_r0;
  logic        m_prev_hs, m_prev_vs;
  int          m_hs_f0, m_hs_f1, m_hs_r0;
  int          m_vs_f0, m_vs_f1, m_vs_r0;
  int          m_fs0, m_fs1;

  initial begin
    // Pixel vectors: filter_select, rddata, expected {r,g,b}
    vecs[0]  = '{1'b0, 12'h000, 24'h000000};
    vecs[1]  = '{1'b0, 12'hF84, 24'hFF8844};
    vecs[2]  = '{1'b0, 12'h123, 24'h112233};
    vecs[3]  = '{1'b0, 12'hFFF, 24'hFFFFFF};
    vecs[4]  = '{1'b1, 12'hF84, 24'h888888};  // (15+16+4)>>2 = 8
    vecs[5]  = '{1'b1, 12'hFFF, 24'hFFFFFF};  // 60>>2 = 15
    vecs[6]  = '{1'b1, 12'h000, 24'h000000};
    vecs[7]  = '{1'b1, 12'h0F0, 24'h777777};  // 30>>2 = 7
    vecs[8]  = '{1'b1, 12'h101, 24'h000000};  // 2>>2 = 0
    vecs[9]  = '{1'b1, 12'hA5C, 24'h888888};  // 32>>2 = 8
    vecs[10] = '{1'b0, 12'h9C3, 24'h99CC33};

    reset_n       = 1'b0;
    m_reset_n     = 1'b0;
    m_filter      = 1'b0;
    filter_select = 1'b0;
    force_en      = 1'b0;
    force_data    = 12'h000;

    // ---------------- reset values ----------------
    repeat (3) step();
    check("rst rdaddress", int'(rdaddress), 0);
    check("rst hs", int'(hs), 1);
    check("rst vs", int'(vs), 1);
    check("rst blank_n", int'(blank_n), 0);
    check("rst rgb", int'({r, g, b}), 0);
    check("rst frame_start", int'(frame_start), 0);
    check("rst m_rdaddress", int'(m_rdaddress), 0);
    check("rst m_frame_start", int'(m_frame_start), 0);

    // ---------------- free run: lines 0..3 against the timing model ----------------
    reset_n = 1'b1;
    k_a     = 0;
    exp_rd  = 0;
    prev_hs = 1'b1;
    hs_f0   = -1;
    hs_f1   = -1;
    hs_r0   = -1;
    for (int i = 0; i < 3 * HT + 4; i++) begin
      step();
      p = k_a - 1;
      h = p % HT;
      v = (p / HT) % VT;
      if (h < HA && v < VA) exp_rd = fb_addr(h, v);
      check($sformatf("rdaddress k=%0d", k_a), int'(rdaddress), exp_rd);
      check($sformatf("frame_start k=%0d", k_a), int'(frame_start), int'(p % (HT * VT) == 0));
      q = k_a - 2;
      if (q < 0) begin
        e_hs  = 1;
        e_vs  = 1;
        e_bl  = 0;
        e_rgb = 24'h0;
      end else begin
        h     = q % HT;
        v     = (q / HT) % VT;
        e_bl  = int'(h < HA && v < VA);
        e_hs  = int'(!(h >= HS0 && h < HS1));
        e_vs  = int'(!(v >= VS0 && v < VS1));
        d     = 12'(fb_addr(h, v));
        e_rgb = (e_bl != 0) ? {d[11:8], d[11:8], d[7:4], d[7:4], d[3:0], d[3:0]} : 24'h0;
      end
      check($sformatf("hs k=%0d", k_a), int'(hs), e_hs);
      check($sformatf("vs k=%0d", k_a), int'(vs), e_vs);
      check($sformatf("blank_n k=%0d", k_a), int'(blank_n), e_bl);
      check($sformatf("rgb k=%0d", k_a), int'({r, g, b}), int'(e_rgb));
      if (prev_hs && !hs) begin
        if (hs_f0 < 0) hs_f0 = k_a;
        else if (hs_f1 < 0) hs_f1 = k_a;
      end
      if (!prev_hs && hs && hs_r0 < 0) hs_r0 = k_a;
      prev_hs = hs;
    end
    check("hs period", hs_f1 - hs_f0, 800);
    check("hs low width", hs_r0 - hs_f0, 96);

    // ---------------- pixel vectors during the visible part of line 3 ----------------
    force_en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step();
      filter_select = vecs[i].fsel;
      force_data    = vecs[i].data;
      #1;
      check($sformatf("vec%0d blank_n", i), int'(blank_n), 1);
      check($sformatf("vec%0d rgb", i), int'({r, g, b}), int'(vecs[i].exp_rgb));
    end

    // ---------------- bright data through porches, filter toggling ----------------
    force_data = 12'hF84;
    for (int i = 0; i < 900; i++) begin
      step();
      fsel          = (k_a % 3 == 0);
      filter_select = fsel;
      #1;
      q    = k_a - 2;
      h    = q % HT;
      v    = (q / HT) % VT;
      e_bl = int'(h < HA && v < VA);
      if (e_bl == 0)  e_rgb = 24'h0;
      else if (fsel)  e_rgb = 24'h888888;
      else            e_rgb = 24'hFF8844;
      check($sformatf("porch blank_n k=%0d", k_a), int'(blank_n), e_bl);
      check($sformatf("porch rgb k=%0d", k_a), int'({r, g, b}), int'(e_rgb));
    end

    // ---------------- asynchronous reset at h=300 of an active line ----------------
    while (((k_a - 2) % HT) != 300) step();
    #2;
    check("pre-reset blank_n", int'(blank_n), 1);
    reset_n = 1'b0;
    #1;
    check("async rdaddress", int'(rdaddress), 0);
    check("async hs", int'(hs), 1);
    check("async vs", int'(vs), 1);
    check("async blank_n", int'(blank_n), 0);
    check("async rgb", int'({r, g, b}), 0);
    check("async frame_start", int'(frame_start), 0);
    force_en      = 1'b0;
    filter_select = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    k_a     = 0;
    step();
    check("restart frame_start", int'(frame_start), 1);
    check("restart rdaddress k1", int'(rdaddress), 0);
    step();
    check("restart frame_start k2", int'(frame_start), 0);
    check("restart rdaddress k2", int'(rdaddress), 0);
    check("restart blank_n k2", int'(blank_n), 1);
    check("restart rgb k2", int'({r, g, b}), 0);
    step();
    check("restart rdaddress k3", int'(rdaddress), 1);

    // ---------------- scaled timing: two full frames ----------------
    m_reset_n = 1'b1;
    k_m       = 0;
    exp_m     = 0;
    max_m     = 0;
    m_prev_hs = 1'b1;
    m_prev_vs = 1'b1;
    m_hs_f0 = -1; m_hs_f1 = -1; m_hs_r0 = -1;
    m_vs_f0 = -1; m_vs_f1 = -1; m_vs_r0 = -1;
    m_fs0   = -1; m_fs1   = -1;
    for (int i = 0; i < 2 * MHT * MVT + 12; i++) begin
      step();
      p = k_m - 1;
      h = p % MHT;
      v = (p / MHT) % MVT;
      if (h < MHA && v < MVA) exp_m = fb_addr(h, v);
      check($sformatf("m_rdaddress k=%0d", k_m), int'(m_rdaddress), exp_m);
      check($sformatf("m_frame_start k=%0d", k_m), int'(m_frame_start), int'(p % (MHT * MVT) == 0));
      if (k_m == 184) check("m last active address", int'(m_rdaddress), 967);
      if (int'(m_rdaddress) > max_m) max_m = int'(m_rdaddress);
      if (m_frame_start) begin
        if (m_fs0 < 0) m_fs0 = k_m;
        else if (m_fs1 < 0) m_fs1 = k_m;
      end
      if (m_prev_hs && !m_hs) begin
        if (m_hs_f0 < 0) m_hs_f0 = k_m;
        else if (m_hs_f1 < 0) m_hs_f1 = k_m;
      end
      if (!m_prev_hs && m_hs && m_hs_r0 < 0 && m_hs_f0 >= 0) m_hs_r0 = k_m;
      if (m_prev_vs && !m_vs) begin
        if (m_vs_f0 < 0) m_vs_f0 = k_m;
        else if (m_vs_f1 < 0) m_vs_f1 = k_m;
      end
      if (!m_prev_vs && m_vs && m_vs_r0 < 0 && m_vs_f0 >= 0) m_vs_r0 = k_m;
      m_prev_hs = m_hs;
      m_prev_vs = m_vs;
    end
    check("m first frame_start", m_fs0, 1);
    check("m frame_start period", m_fs1 - m_fs0, 288);
    check("m hs period", m_hs_f1 - m_hs_f0, 24);
    check("m hs low width", m_hs_r0 - m_hs_f0, 4);
    check("m vs period", m_vs_f1 - m_vs_f0, 288);
    check("m vs low width", m_vs_r0 - m_vs_f0, 48);
    check("m max address", max_m, 967);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
